// File: rtl/lte_hw_acc_pkg.sv
`default_nettype none
// ============================================================================
// lte_hw_acc_pkg : shared constants and types for the LTE accelerator chain
// Rev 1.0
// ============================================================================
package lte_hw_acc_pkg;

    localparam int QPSK_AMP_DEFAULT = 23170;
    localparam int LOF_W            = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        FULL = 2'd2
    } qpsk_state_t;

endpackage
`default_nettype wire

// File: rtl/lte_hw_acc_axis_reg.sv
`default_nettype none
// ============================================================================
// lte_hw_acc_axis_reg : single-stage registered AXI-Stream slice {I, Q, sof, lof}
// Rev 1.0
// ============================================================================
module lte_hw_acc_axis_reg
    import lte_hw_acc_pkg::*;
#(
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 load,
    input  logic [OUT_WIDTH-1:0] in_i,
    input  logic [OUT_WIDTH-1:0] in_q,
    input  logic                 in_sof,
    input  logic [LOF_W-1:0]     in_lof,
    input  logic                 m_ready,
    output logic                 m_valid,
    output logic [OUT_WIDTH-1:0] m_data_i,
    output logic [OUT_WIDTH-1:0] m_data_q,
    output logic                 out_sof,
    output logic [LOF_W-1:0]     out_lof
);

    logic                 valid_d, valid_q;
    logic [OUT_WIDTH-1:0] data_i_d, data_i_q;
    logic [OUT_WIDTH-1:0] data_q_d, data_q_q;
    logic                 sof_d, sof_q;
    logic [LOF_W-1:0]     lof_d, lof_q;

    // The caller only asserts load when the slot is empty or draining.
    always_comb begin
        valid_d  = valid_q;
        data_i_d = data_i_q;
        data_q_d = data_q_q;
        sof_d    = sof_q;
        lof_d    = lof_q;
        if (load) begin
            valid_d  = 1'b1;
            data_i_d = in_i;
            data_q_d = in_q;
            sof_d    = in_sof;
            lof_d    = in_lof;
        end else if (m_ready) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q  <= 1'b0;
            data_i_q <= '0;
            data_q_q <= '0;
            sof_q    <= 1'b0;
            lof_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            data_i_q <= data_i_d;
            data_q_q <= data_q_d;
            sof_q    <= sof_d;
            lof_q    <= lof_d;
        end
    end

    assign m_valid  = valid_q;
    assign m_data_i = data_i_q;
    assign m_data_q = data_q_q;
    assign out_sof  = sof_q;
    assign out_lof  = lof_q;

endmodule
`default_nettype wire

// File: rtl/lte_hw_acc_qpsk_mapper.sv
`default_nettype none
// ============================================================================
// lte_hw_acc_qpsk_mapper : packs scrambled bit pairs into LTE QPSK I/Q symbols
// Rev 1.0
// ============================================================================
module lte_hw_acc_qpsk_mapper
    import lte_hw_acc_pkg::*;
#(
    parameter int OUT_WIDTH = 16,
    parameter int QPSK_AMP  = QPSK_AMP_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 ce,
    input  logic                 s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 in_sof,
    input  logic [LOF_W-1:0]     in_lof,
    output logic [OUT_WIDTH-1:0] m_data_i,
    output logic [OUT_WIDTH-1:0] m_data_q,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 out_sof,
    output logic [LOF_W-1:0]     out_lof,
    output logic                 err_pulse
);

    localparam logic [OUT_WIDTH-1:0] AMP_POS = OUT_WIDTH'(QPSK_AMP);
    localparam logic [OUT_WIDTH-1:0] AMP_NEG = OUT_WIDTH'(-QPSK_AMP);

    qpsk_state_t      state_d, state_q;
    logic [LOF_W-1:0] remain_d, remain_q;
    logic [LOF_W-1:0] lof_d, lof_q;
    logic             held_d, held_q;
    logic             first_d, first_q;
    logic             err_d, err_q;

    logic             s_xfer;
    logic             sym_load;
    logic             sym_b0, sym_b1, sym_sof;
    logic [LOF_W-1:0] sym_lof;
    logic [LOF_W-1:0] new_lof;

    assign s_ready = ce && (!m_valid || m_ready);
    assign s_xfer  = s_valid && s_ready;
    // ceil(in_lof/2) without a carry bit: halve, then round up odd lengths.
    assign new_lof = {1'b0, in_lof[LOF_W-1:1]} + LOF_W'(in_lof[0]);

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        lof_d    = lof_q;
        held_d   = held_q;
        first_d  = first_q;
        err_d    = 1'b0;
        sym_load = 1'b0;
        sym_b0   = 1'b0;
        sym_b1   = 1'b0;
        sym_sof  = 1'b0;
        sym_lof  = lof_q;
        if (s_xfer) begin
            if (in_sof) begin
                // A new sof always restarts; an unfinished frame is an error.
                if (state_q != IDLE) err_d = 1'b1;
                if (in_lof == '0) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (in_lof == LOF_W'(1)) begin
                    sym_load = 1'b1;
                    sym_b0   = s_data;
                    sym_sof  = 1'b1;
                    sym_lof  = LOF_W'(1);
                    lof_d    = LOF_W'(1);
                    first_d  = 1'b0;
                    state_d  = IDLE;
                end else begin
                    held_d   = s_data;
                    remain_d = in_lof - LOF_W'(1);
                    lof_d    = new_lof;
                    first_d  = 1'b1;
                    state_d  = HALF;
                end
            end else begin
                case (state_q)
                    HALF: begin
                        sym_load = 1'b1;
                        sym_b0   = held_q;
                        sym_b1   = s_data;
                        sym_sof  = first_q;
                        first_d  = 1'b0;
                        remain_d = remain_q - LOF_W'(1);
                        state_d  = (remain_q == LOF_W'(1)) ? IDLE : FULL;
                    end
                    FULL: begin
                        if (remain_q == LOF_W'(1)) begin
                            sym_load = 1'b1;
                            sym_b0   = s_data;
                            sym_sof  = first_q;
                            first_d  = 1'b0;
                            remain_d = '0;
                            state_d  = IDLE;
                        end else begin
                            held_d   = s_data;
                            remain_d = remain_q - LOF_W'(1);
                            state_d  = HALF;
                        end
                    end
                    default: err_d = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            remain_q <= '0;
            lof_q    <= '0;
            held_q   <= 1'b0;
            first_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            lof_q    <= lof_d;
            held_q   <= held_d;
            first_q  <= first_d;
            err_q    <= err_d;
        end
    end

    assign err_pulse = err_q;

    lte_hw_acc_axis_reg #(
        .OUT_WIDTH (OUT_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rstn     (rstn),
        .load     (sym_load),
        .in_i     (sym_b0 ? AMP_NEG : AMP_POS),
        .in_q     (sym_b1 ? AMP_NEG : AMP_POS),
        .in_sof   (sym_sof),
        .in_lof   (sym_lof),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_data_i (m_data_i),
        .m_data_q (m_data_q),
        .out_sof  (out_sof),
        .out_lof  (out_lof)
    );

endmodule
`default_nettype wire

// File: tb/tb_lte_hw_acc_qpsk_mapper.sv
`default_nettype none
// ============================================================================
// tb_lte_hw_acc_qpsk_mapper : directed bench with a frame-level symbol model
// Rev 1.0
// ============================================================================
module tb_lte_hw_acc_qpsk_mapper;

    localparam int OW  = 16;
    localparam int AMP = 23170;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          ce = 1'b0;
    logic          s_data = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          in_sof = 1'b0;
    logic [7:0]    in_lof = 8'd0;
    logic [OW-1:0] m_data_i, m_data_q;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          out_sof;
    logic [7:0]    out_lof;
    logic          err_pulse;

    lte_hw_acc_qpsk_mapper #(.OUT_WIDTH(OW), .QPSK_AMP(AMP)) dut (
        .clk(clk), .rstn(rstn), .ce(ce), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .in_sof(in_sof), .in_lof(in_lof),
        .m_data_i(m_data_i), .m_data_q(m_data_q), .m_valid(m_valid),
        .m_ready(m_ready), .out_sof(out_sof), .out_lof(out_lof),
        .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic        sof;
        logic [7:0]  lof;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    err_seen = 0;
    bit    hold_prev = 1'b0;
    beat_t hold_b;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] amp_of(input logic b);
        logic [15:0] p;
        p = 16'(AMP);
        return b ? (~p + 16'd1) : p;
    endfunction

    // Expected symbols for a frame of which only the first nsent bits arrive.
    task automatic model_frame(input logic [31:0] bits, input int nsent, input int lof);
        beat_t b;
        int    nsym;
        nsym = (lof + 1) / 2;
        for (int k = 0; k + 1 < nsent; k += 2) begin
            b.i = amp_of(bits[k]); b.q = amp_of(bits[k+1]);
            b.sof = (k == 0); b.lof = 8'(nsym);
            exp_q.push_back(b);
        end
        if (nsent == lof && (lof % 2) == 1) begin
            b.i = amp_of(bits[lof-1]); b.q = amp_of(1'b0);
            b.sof = (lof == 1); b.lof = 8'(nsym);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_bit(input logic b, input logic sof, input logic [7:0] lof);
        bit done;
        done    = 1'b0;
        s_valid = 1'b1; s_data = b; in_sof = sof; in_lof = lof;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        s_valid = 1'b0; in_sof = 1'b0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input logic [31:0] bits, input int nsend, input int lof);
        for (int k = 0; k < nsend; k++) send_bit(bits[k], k == 0, 8'(lof));
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_beat(input string nm, input beat_t g, input logic [15:0] ei,
                            input logic [15:0] eq, input logic es, input logic [7:0] el);
        chk({nm, "_i"}, 32'(g.i), 32'(ei));
        chk({nm, "_q"}, 32'(g.q), 32'(eq));
        chk({nm, "_sof"}, 32'(g.sof), 32'(es));
        chk({nm, "_lof"}, 32'(g.lof), 32'(el));
    endtask

    // Compare process: every handshake against the model, plus hold stability.
    always @(negedge clk) begin
        beat_t cur, e;
        if (!rstn) begin
            hold_prev = 1'b0;
        end else begin
            cur.i = m_data_i; cur.q = m_data_q; cur.sof = out_sof; cur.lof = out_lof;
            if (hold_prev) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_i", 32'(m_data_i), 32'(hold_b.i));
                chk("hold_q", 32'(m_data_q), 32'(hold_b.q));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(m_data_i), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk_beat("beat", cur, e.i, e.q, e.sof, e.lof);
                    got_q.push_back(cur);
                end
            end
            hold_prev = m_valid && !m_ready;
            hold_b    = cur;
            chk("s_ready", 32'(s_ready), 32'(ce && (!m_valid || m_ready)));
            if (err_pulse) err_seen++;
        end
    end

    initial begin
        int nb;
        beat_t t;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_i", 32'(m_data_i), 32'd0);
        chk("rst_q", 32'(m_data_q), 32'd0);
        chk("rst_sof", 32'(out_sof), 32'd0);
        chk("rst_lof", 32'(out_lof), 32'd0);
        chk("rst_err", 32'(err_pulse), 32'd0);
        rstn = 1'b1; ce = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1;

        // lof=4, bits 1,0,0,1; the model itself is pinned to literals first.
        model_frame(32'b1001, 4, 4);
        chk("model_n", 32'(exp_q.size()), 32'd2);
        t = exp_q[0]; chk_beat("model_b1", t, 16'hA57E, 16'h5A82, 1'b1, 8'd2);
        t = exp_q[1]; chk_beat("model_b2", t, 16'h5A82, 16'hA57E, 1'b0, 8'd2);
        send_frame(32'b1001, 4, 4);
        drain();
        t = got_q[got_q.size()-2]; chk_beat("t1_b1", t, 16'hA57E, 16'h5A82, 1'b1, 8'd2);
        t = got_q[got_q.size()-1]; chk_beat("t1_b2", t, 16'hA57E ^ 16'hFFFC, 16'hA57E, 1'b0, 8'd2);

        // lof=3, bits 1,1,0 with pad.
        err_seen = 0;
        model_frame(32'b011, 3, 3);
        send_frame(32'b011, 3, 3);
        drain();
        t = got_q[got_q.size()-2]; chk_beat("t2_b1", t, 16'hA57E, 16'hA57E, 1'b1, 8'd2);
        t = got_q[got_q.size()-1]; chk_beat("t2_b2", t, 16'h5A82, 16'h5A82, 1'b0, 8'd2);
        chk("t2_err", 32'(err_seen), 32'd0);

        // Backpressure during a 6-bit frame.
        nb = got_q.size();
        model_frame(32'b001110, 6, 6);
        fork
            send_frame(32'b001110, 6, 6);
            begin
                repeat (2) @(posedge clk);
                #2 m_ready = 1'b0;
                repeat (5) @(posedge clk);
                #2 m_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 32'(got_q.size() - nb), 32'd3);

        // Abort: 3 bits of an 8-bit frame, then a fresh 2-bit frame.
        err_seen = 0;
        model_frame(32'b101, 3, 8);
        model_frame(32'b00, 2, 2);
        send_frame(32'b101, 3, 8);
        send_frame(32'b00, 2, 2);
        drain();
        t = got_q[got_q.size()-2]; chk_beat("ab_old", t, 16'hA57E, 16'h5A82, 1'b1, 8'd4);
        t = got_q[got_q.size()-1]; chk_beat("ab_new", t, 16'h5A82, 16'h5A82, 1'b1, 8'd1);
        chk("ab_err", 32'(err_seen), 32'd1);

        // Stray bit in IDLE and sof with lof=0: both dropped with an error.
        err_seen = 0;
        nb = got_q.size();
        send_bit(1'b1, 1'b0, 8'd5);
        send_bit(1'b0, 1'b1, 8'd0);
        drain();
        chk("stray_err", 32'(err_seen), 32'd2);
        chk("stray_nobeat", 32'(got_q.size() - nb), 32'd0);

        // Single-bit frame.
        model_frame(32'b1, 1, 1);
        send_frame(32'b1, 1, 1);
        drain();
        t = got_q[got_q.size()-1]; chk_beat("lof1", t, 16'hA57E, 16'h5A82, 1'b1, 8'd1);

        // ce=0 still lets a pending output drain.
        m_ready = 1'b0;
        model_frame(32'b10, 2, 2);
        send_frame(32'b10, 2, 2);
        chk("ce_full", 32'(m_valid), 32'd1);
        ce = 1'b0; m_ready = 1'b1;
        @(posedge clk); #1;
        chk("ce_drained", 32'(m_valid), 32'd0);
        chk("ce_sready", 32'(s_ready), 32'd0);
        ce = 1'b1;
        drain();

        // Asynchronous reset with a symbol held in the output register.
        m_ready = 1'b0;
        send_frame(32'b10, 2, 4);
        chk("pre_rst_valid", 32'(m_valid), 32'd1);
        #3 rstn = 1'b0;
        #1;
        chk("arst_valid", 32'(m_valid), 32'd0);
        chk("arst_i", 32'(m_data_i), 32'd0);
        chk("arst_sof", 32'(out_sof), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rstn = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1;
        model_frame(32'b0110, 4, 4);
        send_frame(32'b0110, 4, 4);
        drain();
        t = got_q[got_q.size()-2]; chk_beat("post_b1", t, 16'h5A82, 16'hA57E, 1'b1, 8'd2);
        t = got_q[got_q.size()-1]; chk_beat("post_b2", t, 16'hA57E, 16'h5A82, 1'b0, 8'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lte_hw_acc_qpsk_mapper.md
Name: lte_hw_acc_qpsk_mapper

Overview:
- Downstream neighbour of the scrambler in the LTE hardware-accelerator chain.
- Consumes the scrambled 1-bit AXI-Stream with frame markers (sof and length in bits).
- Packs bit pairs into QPSK symbols per the LTE mapping and emits signed I/Q samples with symbol-domain frame markers.
- The output is a registered AXI-Stream stage feeding the resource-element mapper.

Parameters:
- OUT_WIDTH, 16, bit width of each signed I and Q sample.
- QPSK_AMP, 23170, magnitude of each I/Q component (round(2^15/sqrt2)); must fit in OUT_WIDTH-1 bits.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- ce  in  1  clock enable; when low, all state holds and s_ready=0
- s_data  in  1  scrambled bit
- s_valid  in  1  input valid
- s_ready  out  1  input ready
- in_sof  in  1  first bit of frame; qualified by s_valid&&s_ready
- in_lof  in  8  frame length in bits; sampled with in_sof
- m_data_i  out  OUT_WIDTH  signed I sample
- m_data_q  out  OUT_WIDTH  signed Q sample
- m_valid  out  1  output valid
- m_ready  in  1  output ready
- out_sof  out  1  first symbol of frame
- out_lof  out  8  frame length in symbols = ceil(in_lof/2)
- err_pulse  out  1  one-cycle flag for a protocol violation

Behaviour:
- Reset (async, rstn=0): m_valid=0, m_data_i=m_data_q=0, out_sof=0, out_lof=0, err_pulse=0, state=IDLE, bit counter=0, held bit=0. Reset is honoured mid-frame; any partial symbol is discarded.
- Transfer: s_xfer = s_valid && s_ready. The input side is ready when ce=1 and the output register is empty or draining: s_ready = ce && (!m_valid || m_ready).
- Mapping: bit 0 -> +QPSK_AMP; bit 1 -> -QPSK_AMP. The even bit (b0) drives I and the odd bit (b1) drives Q.
- Output register:
  - Loaded on the cycle a symbol completes; latency is 1 clk from the completing bit transfer to m_valid=1.
  - Data and m_valid hold stable while m_valid && !m_ready.
  - m_valid drops after the handshake unless a new symbol loads in the same cycle.
- FSM states:
  - IDLE: no frame is active.
    - s_xfer with in_sof and in_lof>=2: store b0, remain=in_lof-1, latch out_lof=(in_lof+1)>>1, flag first symbol, go to HALF.
    - s_xfer with in_sof and in_lof==1: emit symbol (b0, pad 0) with out_sof=1, out_lof=1; stay in IDLE.
    - s_xfer with in_sof and in_lof==0: drop the bit, pulse err_pulse.
    - s_xfer without in_sof: drop the bit, pulse err_pulse.
  - HALF: one bit is held.
    - s_xfer without in_sof: emit (held, s_data); remain-=1; go to IDLE if remain==1, else go to FULL.
  - FULL: a pair boundary; no bit is held.
    - s_xfer without in_sof: if remain==1, emit (s_data, pad 0) and go to IDLE; else store the bit, remain-=1, go to HALF.
- out_sof=1 only on the first symbol of a frame. out_lof is constant for the whole frame.
- in_sof while in HALF or FULL (abort):
  - The partial frame is dropped, including any held bit, and err_pulse is pulsed.
  - The new frame starts as if from IDLE in the same cycle.
  - Symbols already emitted are unaffected.
- ce=0: FSM and counters freeze. The output register still completes a pending m_ready handshake so the downstream stage cannot deadlock.
- Arithmetic: QPSK_AMP is sign-extended to OUT_WIDTH. The negation is computed at OUT_WIDTH bits; overflow cannot occur given the parameter constraint.
- Throughput: 1 bit/clk sustained, producing 1 symbol per 2 clk with m_ready held high.

Decomposition:
- Shared package lte_hw_acc_pkg holds:
  - the QPSK_AMP default;
  - the state enum typedef qpsk_state_t {IDLE, HALF, FULL};
  - the LOF_W=8 constant.
- One natural sub-module: lte_hw_acc_axis_reg, a single-stage registered AXI-Stream slice carrying {I, Q, sof, lof}. It is reusable across other stages of the chain.

Test Plan:
- in_lof=4, bits 1,0,0,1, m_ready=1 -> two beats:
  - beat 1: (0xA57E, 0x5A82), out_sof=1, out_lof=2;
  - beat 2: (0x5A82, 0xA57E), out_sof=0, out_lof=2.
- in_lof=3, bits 1,1,0 -> beats (0xA57E, 0xA57E) and (0x5A82, 0x5A82 pad), out_lof=2; FSM is in IDLE afterwards.
- Backpressure: hold m_ready=0 for 5 cycles during a 6-bit frame -> s_ready=0 while the output is full; data stays stable; all 3 symbols arrive in order once m_ready=1.
- Abort: in_sof(lof=8) followed by 3 bits, then a new in_sof(lof=2) with bits 0,0 ->
  - err_pulse=1 for exactly 1 cycle;
  - only the first complete symbol from the old frame appears;
  - then (0x5A82, 0x5A82) with out_sof=1, out_lof=1.
- Stray bit with no sof in IDLE, and in_sof with in_lof=0 -> bit accepted and dropped, err_pulse=1, no m_valid.
- Assert rstn=0 asynchronously mid-frame with m_valid=1 -> m_valid=0 immediately, without waiting for a clock edge. A fresh frame after release maps correctly.
